// File: rtl/ram_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals of the shared RAM port arbiter.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10
);
   logic                f_req;
   logic [ADDR_W-1:0]   f_addr;
   logic                f_gnt;
   logic                f_done;
   logic [2*DATA_W-1:0] f_rdata;
   logic                d_req;
   logic                d_we;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic                d_gnt;
   logic                d_done;
   logic [DATA_W-1:0]   d_rdata;
   logic [ADDR_W-1:0]   ram_addr;
   logic                ram_we;
   logic [DATA_W-1:0]   ram_wdata;
   logic [2*DATA_W-1:0] ram_rdata;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
      output ram_addr, ram_we, ram_wdata
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  f_gnt, f_done, f_rdata, d_gnt, d_done, d_rdata,
      input  ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbiter/sequencer sharing one 1024x10 RAM port between instruction fetch
// (pair reads) and data loads/stores; one SERVE cycle per access.
module ram_port_arbiter #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 10,
   parameter bit FETCH_PRIO = 1'b0
) (
   input logic              clk,
   input logic              rst_n,
   ram_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SERVE_F, SERVE_D} state_t;
   typedef enum logic {SRC_F, SRC_D} src_t;

   state_t state;
   src_t   last_served;
   logic   f_win;
   logic   d_win;

   // Tie goes to fetch when it has fixed priority or data was served last.
   always_comb begin
      f_win = 1'b0;
      d_win = 1'b0;
      if (bus.f_req && (!bus.d_req || FETCH_PRIO || last_served == SRC_D))
         f_win = 1'b1;
      else if (bus.d_req)
         d_win = 1'b1;
   end

   // ram_addr/ram_we/ram_wdata double as the latched request fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         last_served   <= SRC_D;
         bus.f_gnt     <= 1'b0;
         bus.d_gnt     <= 1'b0;
         bus.f_done    <= 1'b0;
         bus.d_done    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.f_rdata   <= '0;
         bus.d_rdata   <= '0;
      end else begin
         bus.f_done <= 1'b0;
         bus.d_done <= 1'b0;
         case (state)
            IDLE: begin
               if (f_win) begin
                  state        <= SERVE_F;
                  last_served  <= SRC_F;
                  bus.f_gnt    <= 1'b1;
                  bus.ram_we   <= 1'b0;
                  bus.ram_addr <= {bus.f_addr[ADDR_W-1:1], 1'b0};
               end else if (d_win) begin
                  state         <= SERVE_D;
                  last_served   <= SRC_D;
                  bus.d_gnt     <= 1'b1;
                  bus.ram_we    <= bus.d_we;
                  bus.ram_addr  <= bus.d_addr;
                  bus.ram_wdata <= bus.d_wdata;
               end
            end
            SERVE_F: begin
               state       <= IDLE;
               bus.f_gnt   <= 1'b0;
               bus.f_done  <= 1'b1;
               bus.f_rdata <= bus.ram_rdata;
            end
            SERVE_D: begin
               state      <= IDLE;
               bus.d_gnt  <= 1'b0;
               bus.d_done <= 1'b1;
               bus.ram_we <= 1'b0;
               if (!bus.ram_we)
                  bus.d_rdata <= bus.ram_addr[0] ? bus.ram_rdata[2*DATA_W-1:DATA_W]
                                                 : bus.ram_rdata[DATA_W-1:0];
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed accesses against a RAM model,
// plus a second instance with fixed fetch priority.
module tb_ram_port_arbiter;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   ram_port_arbiter_if #(.ADDR_W(10), .DATA_W(10)) b0 ();
   ram_port_arbiter_if #(.ADDR_W(10), .DATA_W(10)) b1 ();

   ram_port_arbiter #(.ADDR_W(10), .DATA_W(10), .FETCH_PRIO(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.slave));
   ram_port_arbiter #(.ADDR_W(10), .DATA_W(10), .FETCH_PRIO(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: async pair read, sync write; writes are inhibited while the system is in reset.
   logic [9:0] mem [1024];
   bit         mem_init = 1'b0;
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem[10] <= 10'd5;
         mem[11] <= 10'd3;
         mem[14] <= 10'h0F0;
         mem[20] <= 10'h155;
         mem_init <= 1'b1;
      end else if (b0.ram_we && rst_n) begin
         mem[b0.ram_addr] <= b0.ram_wdata;
      end
   end
   assign b0.ram_rdata = {mem[{b0.ram_addr[9:1], 1'b1}], mem[{b0.ram_addr[9:1], 1'b0}]};
   assign b1.ram_rdata = {mem[{b1.ram_addr[9:1], 1'b1}], mem[{b1.ram_addr[9:1], 1'b0}]};

   typedef struct {
      bit         is_f;
      logic [9:0] addr;
      bit         we;
      logic [9:0] wdata;
   } gexp_t;

   gexp_t      gq [$];
   logic [19:0] fq [$];
   logic [9:0]  dq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever dut0 presents a grant or a done pulse.
   always @(negedge clk) begin
      gexp_t g;
      if (b0.f_gnt || b0.d_gnt) begin
         if (gq.size() == 0) begin
            chk("unexpected_gnt", {b0.f_gnt, b0.d_gnt}, 2'b00);
         end else begin
            g = gq.pop_front();
            chk("gnt_side", {b0.f_gnt, b0.d_gnt}, g.is_f ? 2'b10 : 2'b01);
            chk("gnt_ram_addr", b0.ram_addr, g.addr);
            chk("gnt_ram_we", b0.ram_we, g.we);
            if (g.we) chk("gnt_ram_wdata", b0.ram_wdata, g.wdata);
         end
      end else if (b0.ram_we) begin
         chk("stray_ram_we", b0.ram_we, 1'b0);
      end
      if (b0.f_done) begin
         if (fq.size() == 0) chk("unexpected_f_done", b0.f_done, 1'b0);
         else chk("f_rdata", b0.f_rdata, fq.pop_front());
      end
      if (b0.d_done) begin
         if (dq.size() == 0) chk("unexpected_d_done", b0.d_done, 1'b0);
         else chk("d_rdata", b0.d_rdata, dq.pop_front());
      end
   end

   task automatic fetch(input logic [9:0] a, input logic [9:0] exp_addr, input logic [19:0] exp_data);
      int n = 0;
      gq.push_back('{1'b1, exp_addr, 1'b0, 10'h000});
      fq.push_back(exp_data);
      b0.f_addr = a;
      b0.f_req  = 1'b1;
      do begin @(posedge clk); #1; n++; end while (!b0.f_gnt && n < 20);
      chk("f_gnt_latency", n, 1);
      b0.f_req = 1'b0;
      @(posedge clk); #1;
      chk("f_done_latency", b0.f_done, 1'b1);
   endtask

   task automatic dacc(input bit we, input logic [9:0] a, input logic [9:0] wd,
                       input logic [9:0] exp_rd, input bit mutate, input logic [9:0] junk_addr);
      int n = 0;
      gq.push_back('{1'b0, a, we, wd});
      dq.push_back(exp_rd);
      b0.d_we    = we;
      b0.d_addr  = a;
      b0.d_wdata = wd;
      b0.d_req   = 1'b1;
      do begin @(posedge clk); #1; n++; end while (!b0.d_gnt && n < 20);
      chk("d_gnt_latency", n, 1);
      b0.d_req = 1'b0;
      if (mutate) begin
         b0.d_addr  = junk_addr;
         b0.d_we    = ~we;
         b0.d_wdata = 10'h3FF;
      end
      @(posedge clk); #1;
      chk("d_done_latency", b0.d_done, 1'b1);
   endtask

   initial begin
      int n;
      int fcnt;
      rst_n = 1'b0;
      b0.f_req = 1'b0; b0.f_addr = '0; b0.d_req = 1'b0; b0.d_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
      b1.f_req = 1'b0; b1.f_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {b0.f_gnt, b0.d_gnt, b0.f_done, b0.d_done, b0.ram_we}, 5'b0);
      chk("rst_ram_addr", b0.ram_addr, 0);
      chk("rst_ram_wdata", b0.ram_wdata, 0);
      chk("rst_f_rdata", b0.f_rdata, 0);
      chk("rst_d_rdata", b0.d_rdata, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      fetch(10'd11, 10'd10, 20'h00C05);
      dacc(1'b0, 10'd11, 10'h000, 10'h003, 1'b0, 10'd0);
      dacc(1'b0, 10'd10, 10'h000, 10'h005, 1'b0, 10'd0);
      dacc(1'b1, 10'd12, 10'h2A3, 10'h005, 1'b0, 10'd0);
      fetch(10'd12, 10'd12, 20'h002A3);
      dacc(1'b0, 10'd12, 10'h000, 10'h2A3, 1'b0, 10'd0);

      // Both requests held for 8 cycles: round-robin from last_served=DATA.
      gq.push_back('{1'b1, 10'd10, 1'b0, 10'h000});
      gq.push_back('{1'b0, 10'd11, 1'b0, 10'h000});
      gq.push_back('{1'b1, 10'd10, 1'b0, 10'h000});
      gq.push_back('{1'b0, 10'd11, 1'b0, 10'h000});
      fq.push_back(20'h00C05); fq.push_back(20'h00C05);
      dq.push_back(10'h003);   dq.push_back(10'h003);
      b0.f_addr = 10'd10; b0.d_addr = 10'd11; b0.d_we = 1'b0;
      b0.f_req = 1'b1; b0.d_req = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      b0.f_req = 1'b0; b0.d_req = 1'b0;
      @(posedge clk); #1;

      // Request fields changed during the grant cycle must not affect the access.
      dacc(1'b1, 10'd13, 10'h111, 10'h003, 1'b1, 10'd14);
      dacc(1'b0, 10'd14, 10'h000, 10'h0F0, 1'b1, 10'd13);
      dacc(1'b0, 10'd13, 10'h000, 10'h111, 1'b0, 10'd0);

      // Reset during a SERVE_D store.
      gq.push_back('{1'b0, 10'd20, 1'b1, 10'h0AA});
      b0.d_we = 1'b1; b0.d_addr = 10'd20; b0.d_wdata = 10'h0AA; b0.d_req = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b0.d_gnt && n < 20);
      chk("rst_store_gnt_latency", n, 1);
      rst_n = 1'b0; b0.d_req = 1'b0; b0.d_we = 1'b0;
      @(posedge clk); #1;
      chk("rst_abort_ram_we", b0.ram_we, 1'b0);
      chk("rst_abort_no_done", b0.d_done, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_abort_d_done", b0.d_done, 1'b0);
      chk("rst_abort_d_rdata", b0.d_rdata, 0);
      chk("rst_abort_f_rdata", b0.f_rdata, 0);
      chk("rst_abort_mem", mem[20], 10'h155);

      // First tie after reset goes to fetch.
      gq.push_back('{1'b1, 10'd10, 1'b0, 10'h000});
      gq.push_back('{1'b0, 10'd10, 1'b0, 10'h000});
      fq.push_back(20'h00C05);
      dq.push_back(10'h005);
      b0.f_addr = 10'd10; b0.d_addr = 10'd10; b0.d_we = 1'b0;
      b0.f_req = 1'b1; b0.d_req = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b0.f_gnt && n < 20);
      chk("tie_after_rst_f_latency", n, 1);
      b0.f_req = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b0.d_gnt && n < 20);
      chk("tie_after_rst_d_latency", n, 2);
      b0.d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Fixed fetch priority on dut1.
      fcnt = 0;
      b1.f_addr = 10'd10; b1.d_addr = 10'd10; b1.d_we = 1'b0;
      b1.f_req = 1'b1; b1.d_req = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (b1.f_gnt) fcnt++;
         chk("prio_no_d_gnt", b1.d_gnt, 1'b0);
      end
      chk("prio_f_grants", fcnt, 4);
      b1.f_req = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!b1.d_gnt && n < 20);
      chk("prio_d_after_f_drop", n, 1);
      b1.d_req = 1'b0;
      @(posedge clk); #1;
      chk("prio_d_done", b1.d_done, 1'b1);
      chk("prio_d_rdata", b1.d_rdata, 10'h005);

      repeat (3) @(posedge clk);
      #1;
      chk("gq_drained", gq.size(), 0);
      chk("fq_drained", fq.size(), 0);
      chk("dq_drained", dq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
